wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; the array holds 2^ADDR_W entries.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wd_i  input  ADDR_W  destination register from the MEM stage.
REQ-006 SHALL have port wreg_i  input  1  write enable from the MEM stage.
REQ-007 SHALL have port wdata_i  input  DATA_W  write data from the MEM stage.
REQ-008 SHALL have port stall_i  input  1  hold the MEM/WB register and suppress commit.
REQ-009 SHALL have port flush_i  input  1  replace the MEM/WB register contents with a bubble.
REQ-010 SHALL have ports re1_i / re2_i  input  1  read enable for each read port.
REQ-011 SHALL have ports raddr1_i / raddr2_i  input  ADDR_W  read address for each read port.
REQ-012 SHALL have ports rdata1_o / rdata2_o  output  DATA_W  combinational read data.
REQ-013 SHALL have ports wb_wd_o / wb_wreg_o / wb_wdata_o  output  ADDR_W/1/DATA_W  registered MEM/WB contents.
REQ-014 SHALL have port wr_count_o  output  32  count of committed writes.

Function
REQ-015 MEM/WB register: each clock edge, the highest-priority case below SHALL apply.
- rst: load (0, 0, 0).
- flush_i: load (0, 0, 0).
- stall_i: hold the current value.
- otherwise: capture (wd_i, wreg_i, wdata_i).
REQ-016 Commit enable SHALL be wb_wreg_o=1 AND wb_wd_o!=0 AND (stall_i=0 OR flush_i=1) AND rst=0.
REQ-017 On a commit edge, array[wb_wd_o] SHALL be loaded with wb_wdata_o, and wr_count_o SHALL increment by 1.
REQ-018 wr_count_o SHALL wrap from 0xFFFFFFFF to 0.
REQ-019 Register 0 SHALL never be written, and SHALL always read as 0.
REQ-020 Latency: a write presented at the MEM inputs on the cycle before edge N SHALL be captured at edge N and committed at edge N+1, assuming no stall.
REQ-021 Read port k SHALL output the first matching case below.
- rst=1, re_k=0, or raddr_k=0: output 0.
- wreg_i=1 and wd_i=raddr_k: output wdata_i (MEM forward).
- wb_wreg_o=1 and wb_wd_o=raddr_k: output wb_wdata_o (WB forward).
- otherwise: output array[raddr_k].
REQ-022 Both read ports SHALL be independent, and SHALL return identical data for identical addresses in the same cycle.
REQ-023 When flush_i and stall_i are both asserted, the held entry SHALL commit per REQ-016, and the register SHALL then be cleared.
REQ-024 While stall_i=1 (and flush_i=0), a held valid write SHALL remain visible through the WB forward path and SHALL NOT commit or increment the counter.
REQ-025 A write with wd_i=0 SHALL pass through the MEM/WB register unchanged, SHALL NOT commit, and SHALL NOT be forwarded.

Reset
REQ-026 On a reset edge, the following SHALL be cleared to 0: the MEM/WB register, all array entries, and wr_count_o.
REQ-027 Reset asserted mid-operation SHALL discard any pending MEM/WB write without committing it.
REQ-028 All outputs SHALL read 0 while rst=1 and after the first reset edge.

Verification
REQ-029 The bench SHALL cover reset: rst=1 for 2 cycles -> rdata1_o/rdata2_o=0 for addresses 0..31, wb_*_o=0, and wr_count_o=0.
REQ-030 The bench SHALL cover basic write-through: wd_i=3, wreg_i=1, wdata_i=0xDEADBEEF, raddr1_i=3, re1_i=1 -> expected results are below.
- Same cycle: rdata1_o=0xDEADBEEF via MEM forward.
- After edge 1: 0xDEADBEEF via WB forward.
- After edge 2, inputs idle: 0xDEADBEEF from the array, and wr_count_o=1.
REQ-031 The bench SHALL cover register 0: wd_i=0, wreg_i=1, wdata_i=0x1234 for 3 cycles -> a read of r0 returns 0 every cycle, and wr_count_o is unchanged.
REQ-032 The bench SHALL cover stall hold: capture r5=0x55, then stall_i=1 for 3 cycles with inputs r6=0x66 -> expected results are below.
- During the stall: wb_*_o holds (5,1,0x55), a read of r5 returns 0x55, and wr_count_o is unchanged.
- After stall_i=0: r5 commits and wr_count_o+1.
REQ-033 The bench SHALL cover flush+stall: wb holds r7=0x77, then flush_i=1 and stall_i=1 for one edge -> expected results are below.
- array[7]=0x77.
- wr_count_o+1.
- wb_wreg_o=0 next cycle.
REQ-034 The bench SHALL cover forward priority: wb holds r4=0x11, the MEM stage presents r4=0x22 -> expected results are below.
- A read of r4 returns 0x22.
- With re1_i=0, rdata1_o=0.
- With wreg_i=0, the read returns 0x11.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register plus general-purpose register file.
//
// The MEM/WB pipeline register captures the write request coming out of the
// MEM stage. One cycle later the held request is committed into the register
// array, unless the pipeline is stalled. Two combinational read ports see, in
// priority order, the in-flight MEM write, the held WB write and the array.
// This lets a dependent instruction read a result before it is committed.
//
// Parameters
//   DATA_W      register / data width
//   ADDR_W      register address width (array holds 2**ADDR_W entries)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   wd_i        MEM-stage destination register
//   wreg_i      MEM-stage write enable
//   wdata_i     MEM-stage write data
//   stall_i     hold the MEM/WB register and suppress commit
//   flush_i     replace the MEM/WB register with a bubble
//   re1_i/re2_i           read enables
//   raddr1_i/raddr2_i     read addresses
//   rdata1_o/rdata2_o     combinational read data
//   wb_wd_o/wb_wreg_o/wb_wdata_o  registered MEM/WB contents
//   wr_count_o  number of committed writes (wraps)

module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  // MEM stage write request
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  // Pipeline control
  input  logic              stall_i,
  input  logic              flush_i,
  // Read port 1
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  // Read port 2
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  // MEM/WB register contents
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  // Committed write counter
  output logic [31:0]       wr_count_o
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] wb_wd_q, wb_wd_d;
  logic              wb_wreg_q, wb_wreg_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;

  // Flush beats stall; reset is handled in the flop itself.
  always_comb begin
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    if (flush_i) begin
      wb_wd_d    = '0;
      wb_wreg_d  = 1'b0;
      wb_wdata_d = '0;
    end else if (!stall_i) begin
      wb_wd_d    = wd_i;
      wb_wreg_d  = wreg_i;
      wb_wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd_q    <= '0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= '0;
    end else begin
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit
  // ---------------------------------------------------------------------------
  // A flush retires the held entry before clearing it, so flush overrides the
  // stall suppression. Writes to register 0 are dropped here.
  logic commit;

  assign commit = wb_wreg_q && (wb_wd_q != '0) && (!stall_i || flush_i) && !rst;

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [NumRegs];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[wb_wd_q] <= wb_wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Committed write counter
  // ---------------------------------------------------------------------------
  logic [31:0] wr_count_q, wr_count_d;

  // Natural 32-bit overflow provides the wrap to zero.
  always_comb begin
    wr_count_d = wr_count_q;
    if (commit) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // The address-0 test comes first, so a write aimed at r0 is never forwarded.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_in,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic              mem_wreg,
    input logic [ADDR_W-1:0] mem_wd,
    input logic [DATA_W-1:0] mem_wdata,
    input logic              wb_wreg,
    input logic [ADDR_W-1:0] wb_wd,
    input logic [DATA_W-1:0] wb_wdata,
    input logic [DATA_W-1:0] arr_data
  );
    logic [DATA_W-1:0] data;
    if (rst_in || !re || (raddr == '0)) begin
      data = '0;
    end else if (mem_wreg && (mem_wd == raddr)) begin
      data = mem_wdata;
    end else if (wb_wreg && (wb_wd == raddr)) begin
      data = wb_wdata;
    end else begin
      data = arr_data;
    end
    return data;
  endfunction

  always_comb begin
    rdata1_o = read_port(rst, re1_i, raddr1_i, wreg_i, wd_i, wdata_i,
                         wb_wreg_q, wb_wd_q, wb_wdata_q, mem_q[raddr1_i]);
  end

  always_comb begin
    rdata2_o = read_port(rst, re2_i, raddr2_i, wreg_i, wd_i, wdata_i,
                         wb_wreg_q, wb_wd_q, wb_wdata_q, mem_q[raddr2_i]);
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // Masked during reset so every output is 0 even before the first reset edge.
  assign wb_wd_o    = rst ? '0   : wb_wd_q;
  assign wb_wreg_o  = rst ? 1'b0 : wb_wreg_q;
  assign wb_wdata_o = rst ? '0   : wb_wdata_q;
  assign wr_count_o = rst ? '0   : wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: a directed vector table covering reset, write-through,
// register 0, stall, flush+stall, forwarding priority and mid-flight reset,
// followed by random traffic checked against a behavioural model.

module tb_wb_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] wd;
  logic          wreg;
  logic [DW-1:0] wdata;
  logic          stall;
  logic          flush;
  logic          re1, re2;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rd1, rd2;
  logic [AW-1:0] wb_wd;
  logic          wb_wreg;
  logic [DW-1:0] wb_wdata;
  logic [31:0]   wr_count;

  int checks   = 0;
  int failures = 0;

  wb_regfile #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wd_i      (wd),
    .wreg_i    (wreg),
    .wdata_i   (wdata),
    .stall_i   (stall),
    .flush_i   (flush),
    .re1_i     (re1),
    .raddr1_i  (ra1),
    .rdata1_o  (rd1),
    .re2_i     (re2),
    .raddr2_i  (ra2),
    .rdata2_o  (rd2),
    .wb_wd_o   (wb_wd),
    .wb_wreg_o (wb_wreg),
    .wb_wdata_o(wb_wdata),
    .wr_count_o(wr_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs for one cycle and the outputs expected in it
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          rst;
    logic [AW-1:0] wd;
    logic          wreg;
    logic [DW-1:0] wdata;
    logic          stall;
    logic          flush;
    logic          re1;
    logic [AW-1:0] ra1;
    logic          re2;
    logic [AW-1:0] ra2;
    logic [DW-1:0] e_rd1;
    logic [DW-1:0] e_rd2;
    logic [AW-1:0] e_wd;
    logic          e_wreg;
    logic [DW-1:0] e_wdata;
    logic [31:0]   e_cnt;
  } vec_t;

  localparam int NumVec = 24;
  vec_t vecs [NumVec];

  function automatic vec_t mk(
    input logic r, input logic [AW-1:0] d, input logic we, input logic [DW-1:0] dat,
    input logic st, input logic fl, input logic e1, input logic [AW-1:0] a1,
    input logic e2, input logic [AW-1:0] a2, input logic [DW-1:0] x1,
    input logic [DW-1:0] x2, input logic [AW-1:0] xwd, input logic xwe,
    input logic [DW-1:0] xwdat, input logic [31:0] xcnt);
    vec_t v;
    v.rst = r;  v.wd = d;  v.wreg = we;  v.wdata = dat;  v.stall = st;  v.flush = fl;
    v.re1 = e1; v.ra1 = a1; v.re2 = e2; v.ra2 = a2;
    v.e_rd1 = x1; v.e_rd2 = x2; v.e_wd = xwd; v.e_wreg = xwe; v.e_wdata = xwdat;
    v.e_cnt = xcnt;
    return v;
  endfunction

  localparam logic [31:0] D = 32'hDEADBEEF;

  task automatic fill_vecs();
    // write-through of r3
    vecs[0]  = mk(0, 3, 1, D, 0, 0, 1, 3, 1, 3, D, D, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, D, 0, 3, 1, D, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 1, 3, D, D, 0, 0, 0, 1);
    // writes to r0 pass through, never commit, never forward
    vecs[3]  = mk(0, 0, 1, 32'h1234, 0, 0, 1, 0, 1, 3, 0, D, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 1, 32'h1234, 0, 0, 1, 0, 1, 3, 0, D, 0, 1, 32'h1234, 1);
    vecs[5]  = mk(0, 0, 1, 32'h1234, 0, 0, 1, 0, 1, 3, 0, D, 0, 1, 32'h1234, 1);
    // capture r5, stall three cycles with r6 waiting, then release
    vecs[6]  = mk(0, 5, 1, 32'h55, 0, 0, 1, 5, 1, 0, 32'h55, 0, 0, 1, 32'h1234, 1);
    vecs[7]  = mk(0, 6, 1, 32'h66, 1, 0, 1, 5, 1, 6, 32'h55, 32'h66, 5, 1, 32'h55, 1);
    vecs[8]  = mk(0, 6, 1, 32'h66, 1, 0, 1, 5, 1, 6, 32'h55, 32'h66, 5, 1, 32'h55, 1);
    vecs[9]  = mk(0, 6, 1, 32'h66, 1, 0, 1, 5, 1, 6, 32'h55, 32'h66, 5, 1, 32'h55, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 6, 32'h55, 0, 5, 1, 32'h55, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 6, 32'h55, 0, 0, 0, 0, 2);
    // flush+stall retires the held r7 and drops the r8 request
    vecs[12] = mk(0, 7, 1, 32'h77, 0, 0, 1, 7, 1, 5, 32'h77, 32'h55, 0, 0, 0, 2);
    vecs[13] = mk(0, 8, 1, 32'h88, 1, 1, 1, 7, 1, 8, 32'h77, 32'h88, 7, 1, 32'h77, 2);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 7, 1, 8, 32'h77, 0, 0, 0, 0, 3);
    // forward priority on r4: MEM over WB, read enable, WB when MEM idle
    vecs[15] = mk(0, 4, 1, 32'h11, 0, 0, 1, 4, 1, 4, 32'h11, 32'h11, 0, 0, 0, 3);
    vecs[16] = mk(0, 4, 1, 32'h22, 1, 0, 1, 4, 1, 4, 32'h22, 32'h22, 4, 1, 32'h11, 3);
    vecs[17] = mk(0, 4, 1, 32'h22, 1, 0, 0, 4, 1, 4, 0, 32'h22, 4, 1, 32'h11, 3);
    vecs[18] = mk(0, 4, 0, 32'h22, 1, 0, 1, 4, 1, 4, 32'h11, 32'h11, 4, 1, 32'h11, 3);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 4, 1, 3, 32'h11, D, 4, 1, 32'h11, 3);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 4, 1, 7, 32'h11, 32'h77, 0, 0, 0, 4);
    // reset with r9 pending: discarded, array and counter cleared
    vecs[21] = mk(0, 9, 1, 32'h99, 0, 0, 1, 9, 1, 0, 32'h99, 0, 0, 0, 0, 4);
    vecs[22] = mk(1, 0, 0, 0, 0, 0, 1, 9, 1, 4, 0, 0, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 9, 1, 4, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model for random traffic
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_mem [32];
  logic [AW-1:0] m_wd;
  logic          m_wreg;
  logic [DW-1:0] m_wdata;
  logic [31:0]   m_cnt;

  function automatic logic [DW-1:0] m_read(input logic re, input logic [AW-1:0] a);
    if (rst || !re || a == 0) return '0;
    if (wreg && wd == a) return wdata;
    if (m_wreg && m_wd == a) return m_wdata;
    return m_mem[a];
  endfunction

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic m_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_cnt = 0;
      m_wd = 0; m_wreg = 0; m_wdata = 0;
    end else begin
      if (m_wreg && m_wd != 0 && (!stall || flush)) begin
        m_mem[m_wd] = m_wdata;
        m_cnt = m_cnt + 1;
      end
      if (flush) begin
        m_wd = 0; m_wreg = 0; m_wdata = 0;
      end else if (!stall) begin
        m_wd = wd; m_wreg = wreg; m_wdata = wdata;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    wd = '0; wreg = 1'b0; wdata = '0; stall = 1'b0; flush = 1'b0;
    re1 = 1'b1; re2 = 1'b1; ra1 = '0; ra2 = '0;
    fill_vecs();

    // Reset: two edges with rst high; sweep all addresses on both ports.
    @(posedge clk);
    #1;
    for (int s = 0; s < 16; s++) begin
      ra1 = AW'(s);
      ra2 = AW'(s + 16);
      #1;
      chk($sformatf("reset rd1 a=%0d", s), rd1, '0);
      chk($sformatf("reset rd2 a=%0d", s + 16), rd2, '0);
    end
    @(posedge clk);
    #1;
    chk("reset wb_wd", 32'(wb_wd), '0);
    chk("reset wb_wreg", 32'(wb_wreg), '0);
    chk("reset wb_wdata", wb_wdata, '0);
    chk("reset wr_count", wr_count, '0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < NumVec; i++) begin
      rst = vecs[i].rst;     wd = vecs[i].wd;       wreg = vecs[i].wreg;
      wdata = vecs[i].wdata; stall = vecs[i].stall; flush = vecs[i].flush;
      re1 = vecs[i].re1;     ra1 = vecs[i].ra1;
      re2 = vecs[i].re2;     ra2 = vecs[i].ra2;
      @(negedge clk);
      chk($sformatf("vec%0d rd1", i), rd1, vecs[i].e_rd1);
      chk($sformatf("vec%0d rd2", i), rd2, vecs[i].e_rd2);
      chk($sformatf("vec%0d wb_wd", i), 32'(wb_wd), 32'(vecs[i].e_wd));
      chk($sformatf("vec%0d wb_wreg", i), 32'(wb_wreg), 32'(vecs[i].e_wreg));
      chk($sformatf("vec%0d wb_wdata", i), wb_wdata, vecs[i].e_wdata);
      chk($sformatf("vec%0d wr_count", i), wr_count, vecs[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // The table ends just after a reset, so the model starts cleared.
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_wd = 0; m_wreg = 0; m_wdata = 0; m_cnt = 0;

    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      wd    = AW'($urandom_range(0, 31));
      wreg  = ($urandom_range(0, 3) != 0);
      wdata = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      re1   = ($urandom_range(0, 7) != 0);
      re2   = ($urandom_range(0, 7) != 0);
      ra1   = ($urandom_range(0, 3) == 0) ? m_wd : AW'($urandom_range(0, 31));
      ra2   = ($urandom_range(0, 3) == 0) ? ra1  : AW'($urandom_range(0, 31));
      @(negedge clk);
      chk($sformatf("rand%0d rd1", c), rd1, m_read(re1, ra1));
      chk($sformatf("rand%0d rd2", c), rd2, m_read(re2, ra2));
      chk($sformatf("rand%0d wb_wd", c), 32'(wb_wd), rst ? 32'd0 : 32'(m_wd));
      chk($sformatf("rand%0d wb_wreg", c), 32'(wb_wreg), rst ? 32'd0 : 32'(m_wreg));
      chk($sformatf("rand%0d wb_wdata", c), wb_wdata, rst ? 32'd0 : m_wdata);
      chk($sformatf("rand%0d wr_count", c), wr_count, rst ? 32'd0 : m_cnt);
      @(posedge clk);
      m_edge();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
